// File: rtl/rsa_pkg.sv
// Shared state encodings and sizing helpers for the
// word-serial Montgomery exponentiation core.
package rsa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TO_M1,
        S_TO_M2,
        S_SCAN,
        S_SQR,
        S_MUL,
        S_FROM_M,
        S_DONE
    } me_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_RUN,
        M_SUB
    } mm_state_t;

    function automatic int nw_f(input int width, input int word);
        return width / word;
    endfunction

    function automatic int acc_w_f(input int width, input int word);
        return width + word + 1;
    endfunction

endpackage

// File: rtl/mont_mul_ws.sv
// Word-serial CIOS Montgomery multiplier: a*b*R^-1 mod N, fully reduced.
// One digit of a per cycle, then one conditional-subtract cycle.
module mont_mul_ws
    import rsa_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int WORD  = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             mm_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WORD-1:0]  n_prime,
    output logic             mm_done,
    output logic [WIDTH-1:0] mm_result
);

    localparam int NW = nw_f(WIDTH, WORD);
    localparam int AW = acc_w_f(WIDTH, WORD);
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    mm_state_t        r_st;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    logic [WORD-1:0]  w_ai;
    logic [WORD-1:0]  w_t0;
    logic [WORD-1:0]  w_m;
    logic [AW-1:0]    w_nx;
    logic [AW-1:0]    w_sum;
    logic [WIDTH-1:0] w_diff;

    assign w_ai   = r_a[WORD-1:0];
    assign w_t0   = r_acc[WORD-1:0] + w_ai * r_b[WORD-1:0];
    assign w_m    = w_t0 * n_prime;
    assign w_nx   = AW'(modulus);
    // Low WORD bits of w_sum are zero by choice of m; acc stays < 2N.
    assign w_sum  = r_acc + AW'(w_ai) * AW'(r_b) + AW'(w_m) * w_nx;
    assign w_diff = r_acc[WIDTH-1:0] - modulus;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_st   <= M_IDLE;
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_st)
                M_IDLE: begin
                    if (mm_start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_st  <= M_RUN;
                    end
                end
                M_RUN: begin
                    r_acc <= w_sum >> WORD;
                    r_a   <= r_a >> WORD;
                    if (r_cnt == LAST) r_st <= M_SUB;
                    else r_cnt <= r_cnt + CW'(1);
                end
                M_SUB: begin
                    r_res  <= (r_acc >= w_nx) ? w_diff
                                              : r_acc[WIDTH-1:0];
                    r_done <= 1'b1;
                    r_st   <= M_IDLE;
                end
                default: r_st <= M_IDLE;
            endcase
        end
    end

    assign mm_done   = r_done;
    assign mm_result = r_res;

endmodule

// File: rtl/rsa_modexp_ws.sv
// Left-to-right square-and-multiply exponentiation in the Montgomery
// domain, with entry/exit conversion and optional constant-time scan.
module rsa_modexp_ws
    import rsa_pkg::*;
#(
    parameter int WIDTH      = 256,
    parameter int WORD       = 32,
    parameter int EXP_WIDTH  = 32,
    parameter int CONST_TIME = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    input  logic [WIDTH-1:0]     r2_mod,
    input  logic [WORD-1:0]      n_prime,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IW-1:0]    I_TOP = IW'(EXP_WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam bit               CT    = (CONST_TIME != 0);

    me_state_t            r_state;
    logic [WIDTH-1:0]     r_base;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [WIDTH-1:0]     r_mod;
    logic [WIDTH-1:0]     r_r2;
    logic [WORD-1:0]      r_np;
    logic [WIDTH-1:0]     r_xm;
    logic [WIDTH-1:0]     r_am;
    logic [IW-1:0]        r_i;
    logic                 r_wait;
    logic                 r_mm_start;
    logic [WIDTH-1:0]     r_ma;
    logic [WIDTH-1:0]     r_mb;
    logic [WIDTH-1:0]     r_result;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_mm_done;
    logic [WIDTH-1:0]     w_mm_res;
    logic                 w_bit;
    logic                 w_last;

    assign w_bit  = r_exp[r_i];
    assign w_last = (r_i == '0);

    mont_mul_ws #(
        .WIDTH (WIDTH),
        .WORD  (WORD)
    ) u_mm (
        .clk       (clk),
        .rstn      (rstn),
        .mm_start  (r_mm_start),
        .a         (r_ma),
        .b         (r_mb),
        .modulus   (r_mod),
        .n_prime   (r_np),
        .mm_done   (w_mm_done),
        .mm_result (w_mm_res)
    );

    // Each multiply state launches once (r_wait low), then waits for done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_exp      <= '0;
            r_mod      <= '0;
            r_r2       <= '0;
            r_np       <= '0;
            r_xm       <= '0;
            r_am       <= '0;
            r_i        <= '0;
            r_wait     <= 1'b0;
            r_mm_start <= 1'b0;
            r_ma       <= '0;
            r_mb       <= '0;
            r_result   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_mm_start <= 1'b0;
            r_done     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base  <= base;
                        r_exp   <= exponent;
                        r_mod   <= modulus;
                        r_r2    <= r2_mod;
                        r_np    <= n_prime;
                        r_wait  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_TO_M1;
                    end
                end
                S_TO_M1: begin
                    if (!r_wait) begin
                        r_ma <= r_base; r_mb <= r_r2;
                        r_mm_start <= 1'b1; r_wait <= 1'b1;
                    end else if (w_mm_done) begin
                        r_xm    <= w_mm_res;
                        r_wait  <= 1'b0;
                        r_state <= S_TO_M2;
                    end
                end
                S_TO_M2: begin
                    if (!r_wait) begin
                        r_ma <= r_r2; r_mb <= ONE;
                        r_mm_start <= 1'b1; r_wait <= 1'b1;
                    end else if (w_mm_done) begin
                        r_am    <= w_mm_res;
                        r_i     <= I_TOP;
                        r_wait  <= 1'b0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (CT || w_bit) r_state <= S_SQR;
                    else if (w_last) r_state <= S_FROM_M;
                    else r_i <= r_i - IW'(1);
                end
                S_SQR: begin
                    if (!r_wait) begin
                        r_ma <= r_am; r_mb <= r_am;
                        r_mm_start <= 1'b1; r_wait <= 1'b1;
                    end else if (w_mm_done) begin
                        r_am   <= w_mm_res;
                        r_wait <= 1'b0;
                        if (CT || w_bit) r_state <= S_MUL;
                        else if (w_last) r_state <= S_FROM_M;
                        else r_i <= r_i - IW'(1);
                    end
                end
                S_MUL: begin
                    if (!r_wait) begin
                        r_ma <= r_am; r_mb <= r_xm;
                        r_mm_start <= 1'b1; r_wait <= 1'b1;
                    end else if (w_mm_done) begin
                        if (w_bit) r_am <= w_mm_res;
                        r_wait <= 1'b0;
                        if (w_last) begin
                            r_state <= S_FROM_M;
                        end else begin
                            r_i     <= r_i - IW'(1);
                            r_state <= S_SQR;
                        end
                    end
                end
                S_FROM_M: begin
                    if (!r_wait) begin
                        r_ma <= r_am; r_mb <= ONE;
                        r_mm_start <= 1'b1; r_wait <= 1'b1;
                    end else if (w_mm_done) begin
                        r_result <= w_mm_res;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_wait   <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_rsa_modexp_ws.sv
// Directed checks of the exponentiation core: small-modulus vectors,
// constant-time latency, reset abort and wide random vectors.
module tb_rsa_modexp_ws;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic expect_eq(input string tag, input logic [255:0] got,
                             input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic        s_start_a, s_start_c;
    logic [63:0] s_base, s_mod, s_r2;
    logic [31:0] s_exp;
    logic [15:0] s_np;
    logic [63:0] a_result, c_result;
    logic        a_busy, a_done, c_busy, c_done;

    logic         w_start;
    logic [255:0] w_base, w_mod, w_r2, w_result;
    logic [31:0]  w_exp, w_np;
    logic         w_busy, w_done;

    rsa_modexp_ws #(.WIDTH(64), .WORD(16), .EXP_WIDTH(32),
                    .CONST_TIME(0)) u_a (
        .clk(clk), .rstn(rstn), .start(s_start_a), .base(s_base),
        .exponent(s_exp), .modulus(s_mod), .r2_mod(s_r2),
        .n_prime(s_np), .result(a_result), .busy(a_busy),
        .done(a_done));

    rsa_modexp_ws #(.WIDTH(64), .WORD(16), .EXP_WIDTH(32),
                    .CONST_TIME(1)) u_c (
        .clk(clk), .rstn(rstn), .start(s_start_c), .base(s_base),
        .exponent(s_exp), .modulus(s_mod), .r2_mod(s_r2),
        .n_prime(s_np), .result(c_result), .busy(c_busy),
        .done(c_done));

    rsa_modexp_ws #(.WIDTH(256), .WORD(32), .EXP_WIDTH(32),
                    .CONST_TIME(0)) u_w (
        .clk(clk), .rstn(rstn), .start(w_start), .base(w_base),
        .exponent(w_exp), .modulus(w_mod), .r2_mod(w_r2),
        .n_prime(w_np), .result(w_result), .busy(w_busy),
        .done(w_done));

    function automatic logic [31:0] np_of(input logic [31:0] n0);
        logic [31:0] x;
        x = n0;
        for (int i = 0; i < 5; i++) x = x * (32'd2 - n0 * x);
        return -x;
    endfunction

    function automatic logic [255:0] r2_of(input logic [255:0] n);
        logic [512:0] big;
        logic [512:0] nn;
        big = '0;
        big[512] = 1'b1;
        nn = {257'b0, n};
        big = big % nn;
        return big[255:0];
    endfunction

    function automatic logic [255:0] modexp256(input logic [255:0] b,
                                               input logic [31:0] e,
                                               input logic [255:0] n);
        logic [511:0] r, x, nn;
        r = 512'd1;
        x = {256'b0, b};
        nn = {256'b0, n};
        for (int i = 31; i >= 0; i--) begin
            r = (r * r) % nn;
            if (e[i]) r = (r * x) % nn;
        end
        return r[255:0];
    endfunction

    // Start-to-done latency counted in clock edges.
    task automatic run64(input bit ct, input logic [63:0] b,
                         input logic [31:0] e, output logic [63:0] res,
                         output int lat);
        @(negedge clk);
        s_base = b;
        s_exp  = e;
        if (ct) s_start_c = 1'b1;
        else s_start_a = 1'b1;
        @(negedge clk);
        s_start_a = 1'b0;
        s_start_c = 1'b0;
        s_base = ~b;
        s_exp  = ~e;
        expect_eq("busy_rise", ct ? c_busy : a_busy, 1);
        lat = 1;
        while (!(ct ? c_done : a_done) && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        expect_eq("done_seen", ct ? c_done : a_done, 1);
        expect_eq("busy_at_done", ct ? c_busy : a_busy, 0);
        res = ct ? c_result : a_result;
    endtask

    logic [63:0]  r64;
    int           lat, l1, l2, l3, l4, cnt;
    logic [255:0] n, bb, rb;
    logic [31:0]  d;

    initial begin
        s_start_a = 0; s_start_c = 0; w_start = 0;
        s_base = 0; s_exp = 0; s_mod = 64'd7; s_r2 = 64'd4;
        s_np = 16'h9249;
        w_base = 0; w_exp = 0; w_mod = 256'd7; w_r2 = 0; w_np = 0;
        #12;
        expect_eq("rst_result", a_result, 0);
        expect_eq("rst_busy", a_busy, 0);
        expect_eq("rst_done", a_done, 0);
        @(negedge clk);
        rstn = 1'b1;

        run64(0, 64'd3, 32'd5, r64, lat);
        expect_eq("3^5", r64, 5);
        @(negedge clk);
        expect_eq("done_pulse", a_done, 0);
        expect_eq("busy_after", a_busy, 0);
        expect_eq("result_held", a_result, 5);

        run64(0, 64'd6, 32'd2, r64, lat);
        expect_eq("6^2", r64, 1);
        run64(0, 64'd5, 32'd0, r64, lat);
        expect_eq("5^0", r64, 1);
        expect_eq("e0_latency", lat, 57);
        run64(0, 64'd0, 32'hFFFF_FFFF, r64, lat);
        expect_eq("0^ff", r64, 0);
        run64(0, 64'd1, 32'h8000_0000, r64, lat);
        expect_eq("1^80", r64, 1);

        run64(1, 64'd3, 32'd1, r64, l1);
        expect_eq("ct_3^1", r64, 3);
        run64(1, 64'd3, 32'h8000_0000, r64, l2);
        expect_eq("ct_3^80", r64, 2);
        run64(1, 64'd3, 32'hFFFF_FFFF, r64, l3);
        expect_eq("ct_3^ff", r64, 6);
        run64(1, 64'd5, 32'd0, r64, l4);
        expect_eq("ct_5^0", r64, 1);
        expect_eq("ct_lat_80", l2, l1);
        expect_eq("ct_lat_ff", l3, l1);
        expect_eq("ct_lat_0", l4, l1);

        // start coincident with done must be ignored
        run64(0, 64'd3, 32'd5, r64, lat);
        s_start_a = 1'b1;
        @(negedge clk);
        s_start_a = 1'b0;
        expect_eq("start_at_done_busy", a_busy, 0);
        cnt = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (a_done) cnt++;
        end
        expect_eq("start_at_done_nodone", cnt, 0);

        // reset partway through the first squaring
        s_base = 64'd3; s_exp = 32'd5; s_start_a = 1'b1;
        @(negedge clk);
        s_start_a = 1'b0;
        repeat (51) @(negedge clk);
        rstn = 1'b0;
        #1;
        expect_eq("abort_busy", a_busy, 0);
        expect_eq("abort_done", a_done, 0);
        expect_eq("abort_result", a_result, 0);
        @(negedge clk);
        rstn = 1'b1;

        // restart, with a second start while busy
        s_base = 64'd3; s_exp = 32'd5; s_start_a = 1'b1;
        @(negedge clk);
        s_start_a = 1'b0;
        repeat (5) @(negedge clk);
        s_base = 64'd6; s_exp = 32'd2; s_start_a = 1'b1;
        @(negedge clk);
        s_start_a = 1'b0;
        lat = 0;
        while (!a_done && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        expect_eq("restart_done", a_done, 1);
        expect_eq("restart_result", a_result, 5);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (a_done) cnt++;
        end
        expect_eq("busy_start_ignored", cnt, 0);
        expect_eq("result_unchanged", a_result, 5);

        // wide operands against an independent square-and-multiply model
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) begin
                n[j*32 +: 32]  = $urandom();
                rb[j*32 +: 32] = $urandom();
            end
            n[255] = 1'b1;
            n[0]   = 1'b1;
            bb = rb % n;
            d  = $urandom();
            @(negedge clk);
            w_mod = n; w_base = bb; w_exp = d;
            w_np = np_of(n[31:0]); w_r2 = r2_of(n);
            w_start = 1'b1;
            @(negedge clk);
            w_start = 1'b0;
            lat = 1;
            while (!w_done && lat < 5000) begin
                @(negedge clk);
                lat++;
            end
            expect_eq($sformatf("wide_done%0d", k), w_done, 1);
            expect_eq($sformatf("wide%0d", k), w_result,
                      modexp256(bb, d, n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
